// File: rtl/uart_pkg.sv
// Shared types and register map for the MMIO UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Fullness is judged on the pre-pop count: a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports FIFO/FSM state.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned DIV        = 234,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        addr,
  input  logic        rw,
  input  logic [1:0]  word,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        txd,
  output logic        tx_idle
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          r_push_vld;
  logic [7:0]    r_push_byte;
  logic          r_ovf;
  tx_state_t     r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;

  logic          w_push_req;
  logic          w_st_wr;
  logic [7:0]    w_fifo_dout;
  logic [CW-1:0] w_fifo_cnt;
  logic [3:0]    w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_bit_end;
  logic          w_pop;
  logic [63:0]   w_status;
  logic          w_unused;

  assign w_push_req = sel & rw & (addr == REG_TXDATA);
  assign w_st_wr    = sel & rw & (addr == REG_STATUS);
  assign w_bit_end  = (r_baud == 16'(DIV - 1));
  assign w_pop      = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
  assign w_unused   = ^{word, wdata[63:8]};

  // Store requests are registered first, so the FIFO write lands one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_vld  <= 1'b0;
      r_push_byte <= '0;
    end else begin
      r_push_vld  <= w_push_req;
      r_push_byte <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         r_ovf <= 1'b0;
    else if (r_push_vld & w_full)    r_ovf <= 1'b1;
    else if (w_st_wr & wdata[ST_OVF]) r_ovf <= 1'b0;
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_push_vld),
    .i_pop  (w_pop),
    .i_din  (r_push_byte),
    .o_dout (w_fifo_dout),
    .o_count(w_fifo_cnt),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_baud  <= '0;
            r_state <= START;
            r_txd   <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            // Chain straight into the next frame when bytes are waiting.
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_state <= START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_count             = '0;
    w_count[CW-1:0]     = w_fifo_cnt;
    w_status            = '0;
    w_status[ST_FULL]   = w_full;
    w_status[ST_EMPTY]  = w_empty;
    w_status[ST_BUSY]   = (r_state != IDLE);
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_CNT_LSB +: 4] = w_count;
    rdata = '0;
    if (sel & ~rw & (addr == REG_STATUS)) rdata = w_status;
  end

  assign txd     = r_txd;
  assign tx_idle = w_empty & (r_state == IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (DIV=4, FIFO_DEPTH=8).
module tb_uart_tx_mmio;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FD    = 8;
  localparam int          FRAME = 10 * DIV;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sel   = 1'b0;
  logic        addr  = 1'b0;
  logic        rw    = 1'b0;
  logic [1:0]  word  = 2'b00;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        txd;
  logic        tx_idle;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  q [16];
  logic [63:0] st;
  int          e;
  int          e_tmp;
  int          lows;

  uart_tx_mmio #(
    .DIV(DIV),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .addr   (addr),
    .rw     (rw),
    .word   (word),
    .wdata  (wdata),
    .rdata  (rdata),
    .txd    (txd),
    .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic a, input logic [63:0] d, output int e_out);
    sel = 1'b1; rw = 1'b1; addr = a; wdata = d;
    tick();
    e_out = cyc;
    sel = 1'b0; rw = 1'b0; wdata = '0;
  endtask

  task automatic rd_status(output logic [63:0] v);
    sel = 1'b1; rw = 1'b0; addr = 1'b1;
    #1;
    v = rdata;
    sel = 1'b0; addr = 1'b0;
  endtask

  // Expected line level 'off' cycles after the store edge for n queued frames.
  function automatic logic exp_txd(input int off, input int n);
    int rel, f, r;
    if (off < 2) return 1'b1;
    rel = off - 2;
    f   = rel / FRAME;
    if (f >= n) return 1'b1;
    r = rel % FRAME;
    if (r < DIV) return 1'b0;
    if (r < 9 * DIV) return q[f][(r - DIV) / DIV];
    return 1'b1;
  endfunction

  task automatic check_stream(input int e0, input int n);
    while (cyc - e0 <= 2 + n * FRAME) begin
      check_eq("txd", {63'b0, txd}, {63'b0, exp_txd(cyc - e0, n)});
      tick();
    end
    check_eq("tx_idle_after", {63'b0, tx_idle}, 64'd1);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_txd", {63'b0, txd}, 64'd1);
    check_eq("rst_idle", {63'b0, tx_idle}, 64'd1);
    rd_status(st);
    check_eq("rst_status", st, 64'h02);
    rst = 1'b0;
    tick();

    // single frame, exact bit timing
    q[0] = 8'h55;
    store(1'b0, 64'h55, e);
    check_stream(e, 1);

    // back-to-back frames
    q[0] = 8'h01; q[1] = 8'h02; q[2] = 8'h03;
    store(1'b0, 64'h01, e);
    store(1'b0, 64'h02, e_tmp);
    store(1'b0, 64'h03, e_tmp);
    tick();
    rd_status(st);
    check_eq("b2b_status", st, 64'h24);
    check_stream(e, 3);

    // overflow and sticky clear
    for (int i = 0; i < 10; i++) begin
      store(1'b0, 64'(8'h30 + i), e_tmp);
      if (i == 0) e = e_tmp;
      if (i < 9) q[i] = 8'(8'h30 + i);
    end
    tick();
    rd_status(st);
    check_eq("ovf_status", st, 64'h8D);
    store(1'b1, 64'h8, e_tmp);
    rd_status(st);
    check_eq("ovf_clear", st, 64'h85);
    check_stream(e, 9);
    rd_status(st);
    check_eq("ovf_done", st, 64'h02);

    // byte select and load decode
    word = 2'b11;
    sel = 1'b1; rw = 1'b1; addr = 1'b0; wdata = 64'hDEADBEEF_12345641;
    #1;
    check_eq("rdata_store", rdata, 64'h0);
    tick();
    e = cyc;
    sel = 1'b0; rw = 1'b0; wdata = '0; word = 2'b00;
    sel = 1'b1; addr = 1'b0;
    #1;
    check_eq("rdata_txdata", rdata, 64'h0);
    sel = 1'b0; addr = 1'b1;
    #1;
    check_eq("rdata_nosel", rdata, 64'h0);
    addr = 1'b0;
    q[0] = 8'h41;
    check_stream(e, 1);

    // full FIFO with a push landing on the pop edge
    for (int i = 0; i < 9; i++) begin
      store(1'b0, 64'(8'h60 + i), e_tmp);
      if (i == 0) e = e_tmp;
      q[i] = 8'(8'h60 + i);
    end
    while (cyc < e + 40) tick();
    store(1'b0, 64'h69, e_tmp);
    tick();
    rd_status(st);
    check_eq("fullpop_status", st, 64'h7C);
    check_stream(e, 9);
    rd_status(st);
    check_eq("fullpop_ovf", st, 64'h0A);
    store(1'b1, 64'h8, e_tmp);
    rd_status(st);
    check_eq("fullpop_clr", st, 64'h02);

    // reset during data bit 3 with two bytes queued
    store(1'b0, 64'h81, e);
    store(1'b0, 64'h82, e_tmp);
    store(1'b0, 64'h83, e_tmp);
    while (cyc < e + 18) tick();
    check_eq("pre_rst_bit3", {63'b0, txd}, 64'd0);
    rd_status(st);
    check_eq("pre_rst_status", st, 64'h24);
    rst = 1'b1;
    tick();
    check_eq("midrst_txd", {63'b0, txd}, 64'd1);
    check_eq("midrst_idle", {63'b0, tx_idle}, 64'd1);
    rd_status(st);
    check_eq("midrst_status", st, 64'h02);
    rst = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      tick();
      if (!txd) lows++;
    end
    check_eq("no_frames", 64'(lows), 64'd0);
    rd_status(st);
    check_eq("post_rst_status", st, 64'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
